// File: rtl/aes_pkg.sv
// Shared Rijndael constants and index helpers for the ShiftRows datapath
// and the key-expansion / unrolled-round logic that reuses it.
package aes_pkg;

    // State widths in columns for the three legal Rijndael block sizes.
    localparam int NB_128 = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;

    // Row-shift direction, sampled with each block.
    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_INV = 1'b1
    } dir_e;

    // Cyclic left-shift amount of row r.
    // The 256-bit block shifts rows 2 and 3 one column further.
    function automatic int row_offset(input int nb, input int r);
        if (nb == NB_256 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    // Position of state element s[r][c] in FIPS byte order.
    function automatic int byte_idx(input int r, input int c);
        return r + 4 * c;
    endfunction

endpackage

// File: rtl/shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column
// state. Pure wiring plus one 2:1 mux per byte; no clock.
module shiftrows_perm
    import aes_pkg::*;
#(
    parameter int NB = NB_128
) (
    input  logic [32*NB-1:0] state_i,
    input  logic             inverse_i,
    output logic [32*NB-1:0] state_o
);

    // Byte 0 sits in the most significant lane.
    localparam int TOP = 4 * NB - 1;

    if (NB != NB_128 && NB != NB_192 && NB != NB_256) begin : g_bad_nb
        $error("shiftrows_perm: NB=%0d is not one of 4, 6, 8", NB);
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF   = row_offset(NB, r);
            localparam int DST   = byte_idx(r, c);
            localparam int SRC_F = byte_idx(r, (c + OFF) % NB);
            localparam int SRC_I = byte_idx(r, (c - OFF + NB) % NB);

            assign state_o[8*(TOP-DST) +: 8] =
                (dir_e'(inverse_i) == DIR_INV) ? state_i[8*(TOP-SRC_I) +: 8]
                                               : state_i[8*(TOP-SRC_F) +: 8];
        end
    end

endmodule

// File: rtl/shiftrows_pipe.sv
// Elastic, pipelined ShiftRows / InvShiftRows stage. The permutation is
// applied ahead of stage 0; the register stages carry {valid, state, tag}
// and advance like a chain of skid-free pipeline registers.
module shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB          = NB_128,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inverse,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [32*NB-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] done_count
);

    localparam int SW = 32 * NB;

    if (PIPE_STAGES < 1) begin : g_bad_stages
        $error("shiftrows_pipe: PIPE_STAGES=%0d must be at least 1", PIPE_STAGES);
    end

    logic [SW-1:0]          perm_state;
    logic [PIPE_STAGES-1:0] en;
    logic [PIPE_STAGES-1:0] valid_q, valid_d;
    logic [SW-1:0]          state_q [PIPE_STAGES];
    logic [SW-1:0]          state_d [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_d   [PIPE_STAGES];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   handoff;

    shiftrows_perm #(
        .NB (NB)
    ) u_perm (
        .state_i   (in_state),
        .inverse_i (in_inverse),
        .state_o   (perm_state)
    );

    assign handoff    = valid_q[PIPE_STAGES-1] & out_ready;
    assign in_ready   = en[0];
    assign out_valid  = valid_q[PIPE_STAGES-1];
    assign out_state  = state_q[PIPE_STAGES-1];
    assign out_tag    = tag_q[PIPE_STAGES-1];
    assign done_count = cnt_q;

    // A stage may load when some stage at or after it is empty, or the sink drains the head.
    always_comb begin : p_enable
        logic room;
        room = out_ready;
        en   = '0;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
            room  = room | ~valid_q[i];
            en[i] = room;
        end
    end

    // Next state of every stage: take the upstream slot when enabled, otherwise hold.
    always_comb begin : p_next
        // NOTE: each signal written here starts from a full default so no latch is inferred.
        valid_d = valid_q;
        state_d = state_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        if (en[0]) begin
            valid_d[0] = in_valid;
            state_d[0] = perm_state;
            tag_d[0]   = in_tag;
        end
        for (int i = 1; i < PIPE_STAGES; i++) begin
            if (en[i]) begin
                valid_d[i] = valid_q[i-1];
                state_d[i] = state_q[i-1];
                tag_d[i]   = tag_q[i-1];
            end
        end
        if (handoff) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage registers and completed-block counter.
    always_ff @(posedge clk) begin : p_regs
        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        if (reset) begin
            // NOTE: data registers are reset too, because out_state and out_tag must read zero after reset.
            valid_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                state_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            state_q <= state_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Directed bench for shiftrows_pipe: AES-128 vectors, 192/256-bit row offsets
// and round trips, backpressure with two stages, reset with blocks in flight
// and counter wrap.
module tb_shiftrows_pipe;

    localparam logic [127:0] IN1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FWD1 = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] INV1 = 128'h000d0a0704010e0b0805020f0c090603;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // u4: NB=4, one stage
    logic         u4_in_valid, u4_in_ready, u4_in_inverse, u4_out_valid, u4_out_ready;
    logic [3:0]   u4_in_tag, u4_out_tag;
    logic [127:0] u4_in_state, u4_out_state;
    logic [15:0]  u4_done;

    // u8: NB=8, one stage
    logic         u8_in_valid, u8_in_ready, u8_in_inverse, u8_out_valid, u8_out_ready;
    logic [3:0]   u8_in_tag, u8_out_tag;
    logic [255:0] u8_in_state, u8_out_state;
    logic [15:0]  u8_done;

    // u6: NB=6, one stage
    logic         u6_in_valid, u6_in_ready, u6_in_inverse, u6_out_valid, u6_out_ready;
    logic [3:0]   u6_in_tag, u6_out_tag;
    logic [191:0] u6_in_state, u6_out_state;
    logic [15:0]  u6_done;

    // u2: NB=4, two stages
    logic         u2_in_valid, u2_in_ready, u2_in_inverse, u2_out_valid, u2_out_ready;
    logic [3:0]   u2_in_tag, u2_out_tag;
    logic [127:0] u2_in_state, u2_out_state;
    logic [15:0]  u2_done;

    // uc: NB=4, one stage, 4-bit counter
    logic         uc_in_valid, uc_in_ready, uc_in_inverse, uc_out_valid, uc_out_ready;
    logic [3:0]   uc_in_tag, uc_out_tag;
    logic [127:0] uc_in_state, uc_out_state;
    logic [3:0]   uc_done;

    shiftrows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(4), .CNT_W(16)) u4 (
        .clk(clk), .reset(reset), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
        .in_inverse(u4_in_inverse), .in_tag(u4_in_tag), .in_state(u4_in_state),
        .out_valid(u4_out_valid), .out_ready(u4_out_ready), .out_state(u4_out_state),
        .out_tag(u4_out_tag), .done_count(u4_done));

    shiftrows_pipe #(.NB(8), .PIPE_STAGES(1), .TAG_W(4), .CNT_W(16)) u8 (
        .clk(clk), .reset(reset), .in_valid(u8_in_valid), .in_ready(u8_in_ready),
        .in_inverse(u8_in_inverse), .in_tag(u8_in_tag), .in_state(u8_in_state),
        .out_valid(u8_out_valid), .out_ready(u8_out_ready), .out_state(u8_out_state),
        .out_tag(u8_out_tag), .done_count(u8_done));

    shiftrows_pipe #(.NB(6), .PIPE_STAGES(1), .TAG_W(4), .CNT_W(16)) u6 (
        .clk(clk), .reset(reset), .in_valid(u6_in_valid), .in_ready(u6_in_ready),
        .in_inverse(u6_in_inverse), .in_tag(u6_in_tag), .in_state(u6_in_state),
        .out_valid(u6_out_valid), .out_ready(u6_out_ready), .out_state(u6_out_state),
        .out_tag(u6_out_tag), .done_count(u6_done));

    shiftrows_pipe #(.NB(4), .PIPE_STAGES(2), .TAG_W(4), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .in_valid(u2_in_valid), .in_ready(u2_in_ready),
        .in_inverse(u2_in_inverse), .in_tag(u2_in_tag), .in_state(u2_in_state),
        .out_valid(u2_out_valid), .out_ready(u2_out_ready), .out_state(u2_out_state),
        .out_tag(u2_out_tag), .done_count(u2_done));

    shiftrows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(4), .CNT_W(4)) uc (
        .clk(clk), .reset(reset), .in_valid(uc_in_valid), .in_ready(uc_in_ready),
        .in_inverse(uc_in_inverse), .in_tag(uc_in_tag), .in_state(uc_in_state),
        .out_valid(uc_out_valid), .out_ready(uc_out_ready), .out_state(uc_out_state),
        .out_tag(uc_out_tag), .done_count(uc_done));

    task automatic check(input string name, input logic [255:0] observed,
                         input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Inputs change and outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // While u2 is stalled across an edge without reset, its outputs must not move.
    logic [127:0] u2_prev_state;
    logic [3:0]   u2_prev_tag;
    bit           u2_prev_stall = 1'b0;
    always @(negedge clk) begin
        if (u2_prev_stall) begin
            checks++;
            assert (u2_out_state === u2_prev_state && u2_out_tag === u2_prev_tag) else begin
                errors++;
                $error("FAIL hold_stable: observed=%0h/%0h expected=%0h/%0h",
                       u2_out_state, u2_out_tag, u2_prev_state, u2_prev_tag);
            end
        end
        u2_prev_stall = !reset && u2_out_valid && !u2_out_ready;
        u2_prev_state = u2_out_state;
        u2_prev_tag   = u2_out_tag;
    end

    initial begin
        logic [255:0] rnd8, mid8;
        logic [191:0] rnd6, mid6;

        reset = 1'b1;
        {u4_in_valid, u4_in_inverse, u4_in_tag, u4_in_state} = '0; u4_out_ready = 1'b1;
        {u8_in_valid, u8_in_inverse, u8_in_tag, u8_in_state} = '0; u8_out_ready = 1'b1;
        {u6_in_valid, u6_in_inverse, u6_in_tag, u6_in_state} = '0; u6_out_ready = 1'b1;
        {u2_in_valid, u2_in_inverse, u2_in_tag, u2_in_state} = '0; u2_out_ready = 1'b1;
        {uc_in_valid, uc_in_inverse, uc_in_tag, uc_in_state} = '0; uc_out_ready = 1'b1;
        step();
        step();

        // Reset state
        check("rst_out_valid", 256'(u4_out_valid), 256'(0));
        check("rst_out_state", 256'(u4_out_state), 256'(0));
        check("rst_done",      256'(u4_done), 256'(0));
        reset = 1'b0;
        check("rst_in_ready",  256'(u4_in_ready), 256'(1));

        // AES-128 forward, then alternating inverse/forward back to back
        u4_in_valid = 1'b1; u4_in_state = IN1; u4_in_inverse = 1'b0; u4_in_tag = 4'd1;
        step();
        check("fwd128_valid", 256'(u4_out_valid), 256'(1));
        check("fwd128_state", 256'(u4_out_state), 256'(FWD1));
        check("fwd128_tag",   256'(u4_out_tag), 256'(1));
        for (int i = 0; i < 4; i++) begin
            u4_in_inverse = (i % 2 == 0);
            u4_in_tag     = 4'(2 + i);
            step();
            check("mixed_state", 256'(u4_out_state), 256'((i % 2 == 0) ? INV1 : FWD1));
            check("mixed_tag",   256'(u4_out_tag), 256'(2 + i));
        end
        u4_in_valid = 1'b0;
        step();
        check("mixed_drain_valid", 256'(u4_out_valid), 256'(0));
        check("mixed_done",        256'(u4_done), 256'(5));

        // 256-bit and 192-bit blocks with byte k = k
        for (int k = 0; k < 32; k++) u8_in_state[8*(31-k) +: 8] = 8'(k);
        for (int k = 0; k < 24; k++) u6_in_state[8*(23-k) +: 8] = 8'(k);
        u8_in_valid = 1'b1; u8_in_inverse = 1'b0;
        u6_in_valid = 1'b1; u6_in_inverse = 1'b0;
        step();
        check("nb8_fwd_r3c0", 256'(u8_out_state[8*(31-3) +: 8]), 256'(8'h13));
        check("nb8_fwd_r2c0", 256'(u8_out_state[8*(31-2) +: 8]), 256'(8'h0e));
        check("nb8_fwd_r1c0", 256'(u8_out_state[8*(31-1) +: 8]), 256'(8'h05));
        check("nb6_fwd_r3c0", 256'(u6_out_state[8*(23-3) +: 8]), 256'(8'h0f));
        check("nb6_fwd_r2c0", 256'(u6_out_state[8*(23-2) +: 8]), 256'(8'h0a));
        u8_in_inverse = 1'b1;
        u6_in_inverse = 1'b1;
        step();
        check("nb8_inv_r2c0", 256'(u8_out_state[8*(31-2) +: 8]), 256'(8'h16));
        check("nb6_inv_r1c0", 256'(u6_out_state[8*(23-1) +: 8]), 256'(8'h15));

        // Forward then inverse returns the original state
        for (int n = 0; n < 100; n++) begin
            rnd8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rnd6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            u8_in_state = rnd8; u8_in_inverse = 1'b0;
            u6_in_state = rnd6; u6_in_inverse = 1'b0;
            step();
            mid8 = u8_out_state;
            mid6 = u6_out_state;
            u8_in_state = mid8; u8_in_inverse = 1'b1;
            u6_in_state = mid6; u6_in_inverse = 1'b1;
            step();
            check("nb8_roundtrip", u8_out_state, rnd8);
            check("nb6_roundtrip", 256'(u6_out_state), 256'(rnd6));
        end
        u8_in_valid = 1'b0;
        u6_in_valid = 1'b0;

        // Two stages, sink stalled for 5 edges while tags 1,2,3 are offered
        u2_out_ready = 1'b0;
        u2_in_valid  = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            u2_in_tag   = 4'(t);
            u2_in_state = {16{8'(t)}};
            step();
            if (t == 2) begin
                check("bp_in_ready_full", 256'(u2_in_ready), 256'(0));
                check("bp_head_tag", 256'(u2_out_tag), 256'(1));
            end
        end
        for (int s = 0; s < 2; s++) step();
        check("bp_in_ready_held", 256'(u2_in_ready), 256'(0));
        check("bp_head_state",    256'(u2_out_state), 256'({16{8'h01}}));
        check("bp_done_stalled",  256'(u2_done), 256'(0));
        u2_out_ready = 1'b1;
        step();
        u2_in_valid = 1'b0;
        check("bp_release_tag2", 256'(u2_out_tag), 256'(2));
        step();
        check("bp_release_tag3",   256'(u2_out_tag), 256'(3));
        check("bp_release_state3", 256'(u2_out_state), 256'({16{8'h03}}));
        step();
        check("bp_drained", 256'(u2_out_valid), 256'(0));
        check("bp_done",    256'(u2_done), 256'(3));

        // Reset with two blocks in flight
        u2_out_ready = 1'b0;
        u2_in_valid  = 1'b1;
        u2_in_tag = 4'hA; u2_in_state = {16{8'haa}};
        step();
        u2_in_tag = 4'hB; u2_in_state = {16{8'hbb}};
        step();
        check("rif_inflight", 256'(u2_out_valid), 256'(1));
        u2_in_valid = 1'b0;
        reset = 1'b1;
        step();
        check("rif_out_valid", 256'(u2_out_valid), 256'(0));
        check("rif_done",      256'(u2_done), 256'(0));
        check("rif_out_tag",   256'(u2_out_tag), 256'(0));
        reset = 1'b0;
        u2_out_ready = 1'b1;
        check("rif_in_ready", 256'(u2_in_ready), 256'(1));
        for (int s = 0; s < 3; s++) begin
            step();
            check("rif_no_ghost", 256'(u2_out_valid), 256'(0));
        end

        // 4-bit counter wraps after 16 hand-offs
        uc_in_valid = 1'b1;
        for (int b = 0; b < 17; b++) begin
            uc_in_tag   = 4'(b);
            uc_in_state = IN1;
            step();
        end
        check("wrap_at_16",   256'(uc_done), 256'(0));
        check("wrap_last_tag", 256'(uc_out_tag), 256'(0));
        uc_in_valid = 1'b0;
        step();
        check("wrap_done", 256'(uc_done), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
